// File: rtl/mem_sram_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
// Holds the FSM state encoding, default parameter values and the
// byte-address to SRAM-word translation helper.
package mem_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int          DEF_ADDR_W      = 18;
  localparam int          DEF_SRAM_DW     = 16;
  localparam int          DEF_WAIT_CYCLES = 2;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;

  // Word index of a byte address relative to the SRAM base (wraps mod 2^32).
  // The two byte-offset bits fall out of the shift and are thereby ignored.
  function automatic logic [31:0] sram_word_of(input logic [31:0] address,
                                               input logic [31:0] base);
    logic [31:0] offset;
    offset = address - base;
    return offset >> 2;
  endfunction

endpackage

// File: rtl/mem_sram_phase_cnt.sv
// Phase timer for one half-word access. Loading starts a phase of
// WAIT_CYCLES cycles; 'last' flags the final cycle of the running phase and
// 'last_nxt' tells whether the cycle after the coming edge will be a final one,
// which lets the owner register its strobes one cycle ahead.
module mem_sram_phase_cnt #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last,
  output logic last_nxt
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: reload on a new phase, otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = LOAD_VAL;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last     = (count_q == '0);
  assign last_nxt = (count_d == '0);

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory responder for a 16-bit asynchronous SRAM.
// Each 32-bit word is moved as a low half-word then a high half-word, each
// phase lasting WAIT_CYCLES clocks. All pad outputs are registered and are
// decoded from the next FSM state so they change cleanly on clock edges.
// Optional build macro MEM_SRAM_LAST_READ_EN adds a one-entry buffer of the
// last completed read so a repeated load of the same word answers at once.
module mem_sram_ctrl
  import mem_sram_pkg::*;
#(
  parameter int          ADDR_W      = DEF_ADDR_W,
  parameter int          SRAM_DW     = DEF_SRAM_DW,   // must stay 16
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_r_en,
  input  logic               MEM_w_en,
  input  logic [31:0]        address,
  input  logic [31:0]        w_data,
  output logic [31:0]        r_data,
  output logic               ready,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int WORD_W = ADDR_W - 1;

  state_t              state_q, state_d;
  logic                op_wr_q, op_wr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [15:0]         rd_lo_q, rd_lo_d;
  logic [31:0]         r_data_q, r_data_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [15:0]         dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;

  logic                req;
  logic [WORD_W-1:0]   req_word;
  logic                ready_c;
  logic                cnt_load, cnt_en, cnt_last, cnt_last_nxt;
  logic                half_hi;
  logic                lr_hit;
  logic [31:0]         lr_hit_data;

  assign req      = MEM_r_en | MEM_w_en;
  assign req_word = WORD_W'(sram_word_of(address, BASE_ADDR));

  mem_sram_phase_cnt #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .last     (cnt_last),
    .last_nxt (cnt_last_nxt)
  );

`ifdef MEM_SRAM_LAST_READ_EN
  logic              lr_valid_q, lr_valid_d;
  logic [WORD_W-1:0] lr_word_q, lr_word_d;
  logic [31:0]       lr_data_q, lr_data_d;

  // A pure read of the buffered word is answered in IDLE without touching the SRAM.
  assign lr_hit      = (state_q == ST_IDLE) && MEM_r_en && !MEM_w_en &&
                       lr_valid_q && (lr_word_q == req_word);
  assign lr_hit_data = lr_data_q;

  // Buffer update: capture completed reads, keep data coherent with writes.
  always_comb begin
    lr_valid_d = lr_valid_q;
    lr_word_d  = lr_word_q;
    lr_data_d  = lr_data_q;
    if ((state_q == ST_HIGH) && cnt_last && !op_wr_q) begin
      lr_valid_d = 1'b1;
      lr_word_d  = word_q;
      lr_data_d  = {sram_dq_in, rd_lo_q};
    end else if ((state_q == ST_DONE) && op_wr_q && lr_valid_q &&
                 (lr_word_q == word_q)) begin
      lr_data_d  = wdata_q;
    end
  end

  // Buffer registers; reset invalidates the entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lr_valid_q <= 1'b0;
      lr_word_q  <= '0;
      lr_data_q  <= '0;
    end else begin
      lr_valid_q <= lr_valid_d;
      lr_word_q  <= lr_word_d;
      lr_data_q  <= lr_data_d;
    end
  end

  assign r_data = lr_hit ? lr_data_q : r_data_q;
`else
  assign lr_hit      = 1'b0;
  assign lr_hit_data = '0;
  assign r_data      = r_data_q;
`endif

  // FSM next state, request latching and read-data capture.
  always_comb begin
    state_d  = state_q;
    op_wr_d  = op_wr_q;
    word_d   = word_q;
    wdata_d  = wdata_q;
    rd_lo_d  = rd_lo_q;
    r_data_d = r_data_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    ready_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready_c = ~req | lr_hit;
        if (lr_hit) begin
          r_data_d = lr_hit_data;
        end else if (req) begin
          // Write wins when both enables are high.
          op_wr_d  = MEM_w_en;
          word_d   = req_word;
          wdata_d  = w_data;
          cnt_load = 1'b1;
          state_d  = ST_LOW;
        end
      end
      ST_LOW: begin
        if (cnt_last) begin
          if (!op_wr_q) rd_lo_d = sram_dq_in;
          cnt_load = 1'b1;
          state_d  = ST_HIGH;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_last) begin
          // Low half was staged so r_data only changes once the word is whole.
          if (!op_wr_q) r_data_d = {sram_dq_in, rd_lo_q};
          state_d = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        // Request is deliberately not re-sampled here.
        ready_c = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pad output decode from the upcoming state so the registered pins line up with it.
  always_comb begin
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    half_hi     = (state_d == ST_HIGH);
    if ((state_d == ST_LOW) || (state_d == ST_HIGH)) begin
      sram_addr_d = {word_d, half_hi};
      if (op_wr_d) begin
        dq_oe_d  = 1'b1;
        dq_out_d = half_hi ? wdata_d[31:16] : wdata_d[15:0];
        // Release the strobe for the final phase cycle so address/data outlast it.
        we_n_d   = cnt_last_nxt;
      end else begin
        oe_n_d = 1'b0;
      end
    end
  end

  // State and output registers; reset aborts any access and parks the pads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      rd_lo_q     <= '0;
      r_data_q    <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_wr_q     <= op_wr_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      rd_lo_q     <= rd_lo_d;
      r_data_q    <= r_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
    end
  end

  assign ready       = ready_c;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;

endmodule
